// File: rtl/lif_layer_seq.sv
// Time-multiplexed integrate-and-fire layer: scans one spike vector against a weight memory, then updates all neurons.
// Optional leak toward the rest potential is compiled in when LIF_LEAK_EN is defined.
module lif_layer_seq #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_OUTPUTS = 100,
  parameter int WEIGHT_SIZE = 4,
  parameter int V_WIDTH     = 40,
  parameter logic signed [V_WIDTH-1:0] THRESH = 40'sd25769803776,
  parameter logic signed [V_WIDTH-1:0] RESET  = 40'sd10737418240,
  parameter int REFRAC      = 5,
  parameter logic signed [V_WIDTH-1:0] LEAK   = 40'sd1,
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS-1:0]            spike_in,
  output logic                             out_valid,
  output logic [NUM_OUTPUTS-1:0]           spike_out,
  input  logic                             w_we,
  input  logic [AW-1:0]                    w_addr,
  input  logic [NUM_OUTPUTS*WEIGHT_SIZE-1:0] w_data
);

  localparam int IW    = $clog2(NUM_INPUTS + 1);
  localparam int RW    = $clog2(REFRAC + 2);
  localparam int ROW_W = NUM_OUTPUTS * WEIGHT_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [NUM_INPUTS-1:0]       spikes_q, spikes_d;
  logic signed [V_WIDTH-1:0]   v_q [NUM_OUTPUTS];
  logic signed [V_WIDTH-1:0]   v_d [NUM_OUTPUTS];
  logic [RW-1:0]               refrac_q [NUM_OUTPUTS];
  logic [RW-1:0]               refrac_d [NUM_OUTPUTS];
  logic                        out_valid_q, out_valid_d;
  logic [NUM_OUTPUTS-1:0]      spike_out_q, spike_out_d;
  logic [ROW_W-1:0]            w_mem [NUM_INPUTS];
  logic [ROW_W-1:0]            rd_q;
  logic [AW-1:0]               rd_addr_s;
  logic                        w_addr_ok_s;

  // Saturating add of a sign-extended weight to a membrane potential.
  function automatic logic signed [V_WIDTH-1:0] sat_add(input logic signed [V_WIDTH-1:0] v,
                                                        input logic signed [WEIGHT_SIZE-1:0] w);
    logic signed [V_WIDTH:0] s;
    s = {v[V_WIDTH-1], v} + {{(V_WIDTH+1-WEIGHT_SIZE){w[WEIGHT_SIZE-1]}}, w};
    if (s[V_WIDTH] != s[V_WIDTH-1]) begin
      sat_add = s[V_WIDTH] ? {1'b1, {(V_WIDTH-1){1'b0}}} : {1'b0, {(V_WIDTH-1){1'b1}}};
    end else begin
      sat_add = s[V_WIDTH-1:0];
    end
  endfunction

`ifdef LIF_LEAK_EN
  // One leak step toward RESET, never overshooting it.
  function automatic logic signed [V_WIDTH-1:0] leak_step(input logic signed [V_WIDTH-1:0] v);
    logic signed [V_WIDTH:0] ext_v, ext_r, ext_l, t;
    ext_v = {v[V_WIDTH-1], v};
    ext_r = {RESET[V_WIDTH-1], RESET};
    ext_l = {LEAK[V_WIDTH-1], LEAK};
    if (v > RESET) begin
      t = ext_v - ext_l;
      leak_step = (t < ext_r) ? RESET : t[V_WIDTH-1:0];
    end else if (v < RESET) begin
      t = ext_v + ext_l;
      leak_step = (t > ext_r) ? RESET : t[V_WIDTH-1:0];
    end else begin
      leak_step = v;
    end
  endfunction
`else
  logic unused_leak_s;
  assign unused_leak_s = ^LEAK;
`endif

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign spike_out   = spike_out_q;
  assign w_addr_ok_s = ({1'b0, w_addr} < (AW+1)'(NUM_INPUTS));

  // Weight rows are written only while idle and survive rst_n.
  always_ff @(posedge clk) begin
    if (w_we && (state_q == S_IDLE) && w_addr_ok_s) begin
      w_mem[w_addr] <= w_data;
    end
  end

  // Synchronous weight read: row addressed this cycle is summed next cycle.
  always_ff @(posedge clk) begin
    rd_q <= w_mem[rd_addr_s];
  end

  // Next-state, accumulation and neuron update.
  always_comb begin
    logic signed [V_WIDTH-1:0] v_tmp;
    v_tmp       = '0;
    state_d     = state_q;
    idx_d       = idx_q;
    spikes_d    = spikes_q;
    v_d         = v_q;
    refrac_d    = refrac_q;
    out_valid_d = 1'b0;
    spike_out_d = spike_out_q;
    rd_addr_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          spikes_d = spike_in;
          idx_d    = '0;
          state_d  = S_ACCUM;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (idx_q < IW'(NUM_INPUTS)) begin
          rd_addr_s = AW'(idx_q);
        end else begin
          rd_addr_s = '0;
        end
        // spikes_q shifts once per summed row, so bit 0 always gates the row read last cycle.
        if (idx_q != '0) begin
          if (spikes_q[0]) begin
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
              v_d[n] = sat_add(v_q[n], rd_q[n*WEIGHT_SIZE +: WEIGHT_SIZE]);
            end
          end else begin
            v_d = v_q;
          end
          spikes_d = spikes_q >> 1;
        end else begin
          spikes_d = spikes_q;
        end
        if (idx_q == IW'(NUM_INPUTS)) begin
          state_d = S_UPDATE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_UPDATE: begin
        for (int n = 0; n < NUM_OUTPUTS; n++) begin
          spike_out_d[n] = 1'b0;
          if (refrac_q[n] != '0) begin
            v_d[n]      = RESET;
            refrac_d[n] = refrac_q[n] - RW'(1);
          end else begin
            v_tmp = v_q[n];
`ifdef LIF_LEAK_EN
            v_tmp = leak_step(v_tmp);
`endif
            if (v_tmp >= THRESH) begin
              spike_out_d[n] = 1'b1;
              v_d[n]         = RESET;
              refrac_d[n]    = RW'(REFRAC);
            end else begin
              v_d[n]         = v_tmp;
            end
          end
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, neuron and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      spikes_q    <= '0;
      out_valid_q <= 1'b0;
      spike_out_q <= '0;
      for (int n = 0; n < NUM_OUTPUTS; n++) begin
        v_q[n]      <= RESET;
        refrac_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spikes_q    <= spikes_d;
      out_valid_q <= out_valid_d;
      spike_out_q <= spike_out_d;
      v_q         <= v_d;
      refrac_q    <= refrac_d;
    end
  end

endmodule

// File: tb/tb_lif_layer_seq.sv
// Bench for lif_layer_seq: two small instances (16-bit and 6-bit potentials) share stimulus and
// are checked against an arithmetic reference model of the integrate/fire/refractory rules.
module tb_lif_layer_seq;

  localparam int NI = 4;
  localparam int NO = 2;
  localparam int LAT = NI + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [NI-1:0] spike_in = '0;
  logic w_we = 1'b0;
  logic [1:0] w_addr = '0;
  logic [NO*4-1:0] w_data = '0;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [NO-1:0] spike_out_a, spike_out_b;

  lif_layer_seq #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .WEIGHT_SIZE(4), .V_WIDTH(16),
                  .THRESH(16'sd10), .RESET(16'sd0), .REFRAC(2), .LEAK(16'sd1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .spike_in(spike_in),
    .out_valid(out_valid_a), .spike_out(spike_out_a), .w_we(w_we), .w_addr(w_addr), .w_data(w_data));

  lif_layer_seq #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .WEIGHT_SIZE(4), .V_WIDTH(6),
                  .THRESH(6'sd20), .RESET(6'sd0), .REFRAC(2), .LEAK(6'sd1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .spike_in(spike_in),
    .out_valid(out_valid_b), .spike_out(spike_out_b), .w_we(w_we), .w_addr(w_addr), .w_data(w_data));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: [instance][neuron]
  longint mv[2][NO];
  int     mr[2][NO];
  int     wt[NI][NO];
  int     vw_m[2]  = '{16, 6};
  longint thr_m[2] = '{10, 20};
  logic [NO-1:0] exp_s[2];

  // observations of the last timestep
  int     obs_lat;
  logic [NO-1:0] obs_s[2];
  longint obs_v[2][NO];

  function automatic int sx4(input logic [3:0] x);
    logic signed [3:0] t;
    t = x;
    return int'(t);
  endfunction

  function automatic longint sat(input longint x, input int vw);
    longint lo, hi;
    hi = (longint'(1) <<< (vw - 1)) - 1;
    lo = -(longint'(1) <<< (vw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < NO; n++) begin
        mv[k][n] = 0;
        mr[k][n] = 0;
      end
  endtask

  task automatic model_step(input logic [NI-1:0] s);
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < NO; n++) begin
        longint acc;
        acc = mv[k][n];
        for (int i = 0; i < NI; i++)
          if (s[i]) acc = sat(acc + wt[i][n], vw_m[k]);
        exp_s[k][n] = 1'b0;
        if (mr[k][n] > 0) begin
          mv[k][n] = 0;
          mr[k][n] = mr[k][n] - 1;
        end else begin
`ifdef LIF_LEAK_EN
          if (acc > 0) acc = acc - 1;
          else if (acc < 0) acc = acc + 1;
`endif
          if (acc >= thr_m[k]) begin
            exp_s[k][n] = 1'b1;
            mv[k][n] = 0;
            mr[k][n] = 2;
          end else begin
            mv[k][n] = acc;
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; w_we = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_row(input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = addr; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    wt[addr][0] = sx4(d[3:0]);
    wt[addr][1] = sx4(d[7:4]);
  endtask

  // Accept one timestep (optionally with a same-edge weight write) and collect its result.
  task automatic run_step(input logic [NI-1:0] s, input logic we, input logic [1:0] addr, input logic [7:0] d);
    int cnt;
    @(negedge clk);
    in_valid = 1'b1; spike_in = s; w_we = we; w_addr = addr; w_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; w_we = 1'b0;
    if (we) begin
      wt[addr][0] = sx4(d[3:0]);
      wt[addr][1] = sx4(d[7:4]);
    end
    model_step(s);
    @(negedge clk);
    cnt = 1;
    while (!out_valid_a && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    obs_lat = cnt;
    obs_s[0] = spike_out_a;
    obs_s[1] = spike_out_b;
    obs_v[0][0] = longint'(dut_a.v_q[0]);
    obs_v[0][1] = longint'(dut_a.v_q[1]);
    obs_v[1][0] = longint'(dut_b.v_q[0]);
    obs_v[1][1] = longint'(dut_b.v_q[1]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || spike_out_a !== 2'b00 ||
        in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || spike_out_b !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_held: ready=%b valid=%b spikes=%b, expected 1 0 00", in_ready_a, out_valid_a, spike_out_a);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || spike_out_a !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b spikes=%b, expected 1 0 00", in_ready_a, out_valid_a, spike_out_a);
    end
    for (int r = 0; r < NI; r++) write_row(2'(r), 8'h00);
    run_step(4'b1111, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (obs_lat !== LAT || obs_s[0] !== 2'b00 || obs_s[1] !== 2'b00 || obs_v[0][0] != 0 || obs_v[1][1] != 0) begin
      miscompares++;
      $display("FAIL zero_weights: lat=%0d a=%b b=%b, expected lat=%0d 00 00", obs_lat, obs_s[0], obs_s[1], LAT);
    end
  endtask

  task automatic test_integrate_fire();
    logic [NO-1:0] req[6];
    req = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    apply_reset();
    write_row(2'd0, 8'h75);
    for (int r = 1; r < NI; r++) write_row(2'(r), 8'h00);
    for (int i = 0; i < 6; i++) begin
      run_step(4'b0001, 1'b0, 2'd0, 8'h00);
      vectors++;
      if (obs_lat !== LAT || obs_s[0] !== req[i] || obs_s[0] !== exp_s[0] || obs_s[1] !== exp_s[1]) begin
        miscompares++;
        $display("FAIL integrate step %0d: lat=%0d a=%b b=%b, expected lat=%0d a=%b b=%b",
                 i + 1, obs_lat, obs_s[0], obs_s[1], LAT, req[i], exp_s[1]);
      end
      vectors++;
      if (obs_v[0][0] != mv[0][0] || obs_v[0][1] != mv[0][1] || obs_v[1][0] != mv[1][0] || obs_v[1][1] != mv[1][1]) begin
        miscompares++;
        $display("FAIL integrate_v step %0d: v=%0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d", i + 1,
                 obs_v[0][0], obs_v[0][1], obs_v[1][0], obs_v[1][1], mv[0][0], mv[0][1], mv[1][0], mv[1][1]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [NO-1:0] ea, eb;
    apply_reset();
    write_row(2'd0, 8'h75);
    write_row(2'd1, 8'h22);
    write_row(2'd2, 8'h00);
    write_row(2'd3, 8'h00);
    @(negedge clk);
    in_valid = 1'b1; spike_in = 4'b0001;
    @(posedge clk);
    model_step(4'b0001);
    ea = exp_s[0]; eb = exp_s[1];
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      vectors++;
      if (in_ready_a !== (j == LAT) || out_valid_a !== (j == LAT) ||
          in_ready_b !== (j == LAT) || out_valid_b !== (j == LAT)) begin
        miscompares++;
        $display("FAIL handshake1 cycle %0d: ready=%b valid=%b, expected %b %b", j, in_ready_a, out_valid_a, j == LAT, j == LAT);
      end
      if (j == 1) spike_in = 4'b1111;
      w_we = (j == 2); w_addr = 2'd0; w_data = 8'h11;
      if (j == LAT) begin
        vectors++;
        if (spike_out_a !== ea || spike_out_b !== eb) begin
          miscompares++;
          $display("FAIL handshake1 spikes: a=%b b=%b, expected a=%b b=%b", spike_out_a, spike_out_b, ea, eb);
        end
        spike_in = 4'b0000;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_step(4'b0000);
    for (int j = 1; j <= LAT + 3; j++) begin
      @(negedge clk);
      vectors++;
      if (in_ready_a !== (j >= LAT) || out_valid_a !== (j == LAT)) begin
        miscompares++;
        $display("FAIL handshake2 cycle %0d: ready=%b valid=%b, expected %b %b", j, in_ready_a, out_valid_a, j >= LAT, j == LAT);
      end
      if (j == LAT) begin
        vectors++;
        if (spike_out_a !== exp_s[0] || spike_out_b !== exp_s[1]) begin
          miscompares++;
          $display("FAIL handshake2 spikes: a=%b b=%b, expected a=%b b=%b", spike_out_a, spike_out_b, exp_s[0], exp_s[1]);
        end
      end
    end
    run_step(4'b0001, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (obs_lat !== LAT || obs_s[0] !== exp_s[0] || obs_s[1] !== exp_s[1] || obs_v[0][1] != mv[0][1]) begin
      miscompares++;
      $display("FAIL busy_write_ignored: a=%b b=%b v=%0d, expected a=%b b=%b v=%0d",
               obs_s[0], obs_s[1], obs_v[0][1], exp_s[0], exp_s[1], mv[0][1]);
    end
  endtask

  task automatic test_saturation();
    longint req_b[5];
    req_b = '{-8, -16, -24, -32, -32};
    apply_reset();
    write_row(2'd0, 8'h08);
    write_row(2'd1, 8'h07);
    write_row(2'd2, 8'h00);
    write_row(2'd3, 8'h00);
    for (int i = 0; i < 14; i++) begin
      run_step((i < 5) ? 4'b0001 : 4'b0010, 1'b0, 2'd0, 8'h00);
      vectors++;
      if (obs_lat !== LAT || obs_s[0] !== exp_s[0] || obs_s[1] !== exp_s[1] ||
          obs_v[0][0] != mv[0][0] || obs_v[1][0] != mv[1][0] || (i < 5 && obs_v[1][0] != req_b[i])) begin
        miscompares++;
        $display("FAIL saturate step %0d: a=%b b=%b va=%0d vb=%0d, expected a=%b b=%b va=%0d vb=%0d", i + 1,
                 obs_s[0], obs_s[1], obs_v[0][0], obs_v[1][0], exp_s[0], exp_s[1], mv[0][0], mv[1][0]);
      end
    end
  endtask

  task automatic test_leak();
    longint req[4];
`ifdef LIF_LEAK_EN
    req = '{4, 3, 2, 1};
`else
    req = '{5, 5, 5, 5};
`endif
    apply_reset();
    write_row(2'd0, 8'h05);
    for (int r = 1; r < NI; r++) write_row(2'(r), 8'h00);
    for (int i = 0; i < 4; i++) begin
      run_step((i == 0) ? 4'b0001 : 4'b0000, 1'b0, 2'd0, 8'h00);
      vectors++;
      if (obs_v[0][0] != req[i] || obs_v[0][0] != mv[0][0] || obs_v[1][0] != mv[1][0] || obs_s[0] !== 2'b00) begin
        miscompares++;
        $display("FAIL leak step %0d: va=%0d vb=%0d spikes=%b, expected va=%0d vb=%0d spikes=00",
                 i + 1, obs_v[0][0], obs_v[1][0], obs_s[0], req[i], mv[1][0]);
      end
    end
  endtask

  task automatic test_reset_mid_accum();
    apply_reset();
    write_row(2'd0, 8'h75);
    for (int r = 1; r < NI; r++) write_row(2'(r), 8'h00);
    run_step(4'b0001, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    in_valid = 1'b1; spike_in = 4'b0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < LAT + 2; j++) begin
      @(negedge clk);
      vectors++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_valid_b !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: valid=%b ready=%b, expected 0 1", j, out_valid_a, in_ready_a);
      end
    end
    run_step(4'b0001, 1'b0, 2'd0, 8'h00);
    vectors++;
    if (obs_lat !== LAT || obs_v[0][0] != 5 || obs_v[0][1] != 7 || obs_s[0] !== exp_s[0] || obs_v[1][1] != mv[1][1]) begin
      miscompares++;
      $display("FAIL reset_mid_restart: lat=%0d v=%0d/%0d spikes=%b, expected lat=%0d v=5/7 spikes=%b",
               obs_lat, obs_v[0][0], obs_v[0][1], obs_s[0], LAT, exp_s[0]);
    end
  endtask

  task automatic test_random();
    logic [NI-1:0] s;
    logic we;
    apply_reset();
    for (int r = 0; r < NI; r++) write_row(2'(r), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      s = NI'($urandom);
      if ($urandom_range(0, 3) == 0) write_row(2'($urandom), 8'($urandom));
      we = ($urandom_range(0, 3) == 0);
      run_step(s, we, 2'($urandom), 8'($urandom));
      vectors++;
      if (obs_lat !== LAT || obs_s[0] !== exp_s[0] || obs_s[1] !== exp_s[1] ||
          obs_v[0][0] != mv[0][0] || obs_v[0][1] != mv[0][1] || obs_v[1][0] != mv[1][0] || obs_v[1][1] != mv[1][1]) begin
        miscompares++;
        $display("FAIL random step %0d: lat=%0d a=%b b=%b v=%0d/%0d/%0d/%0d, expected a=%b b=%b v=%0d/%0d/%0d/%0d",
                 i, obs_lat, obs_s[0], obs_s[1], obs_v[0][0], obs_v[0][1], obs_v[1][0], obs_v[1][1],
                 exp_s[0], exp_s[1], mv[0][0], mv[0][1], mv[1][0], mv[1][1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_integrate_fire();
    test_handshake();
    test_saturation();
    test_leak();
    test_reset_mid_accum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
